dm_store_buffer: RTL

//  Posted-write FIFO between the MEM-stage load/store unit and the 4 KB data memory (dm_4k).

---
 rtl/dm_store_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dm_store_buffer.sv
// ---------------------------------------------------------------------------
// dm_store_buffer
//   Posted-write FIFO between the MEM-stage load/store unit and dm_4k.
//   Stores retire into the buffer in one cycle and drain to dm_4k later, on
//   cycles when no load owns the single memory port. Loads read dm_4k
//   directly; a load whose word matches any pending store stalls until that
//   store has drained (no forwarding). A full buffer always drains so that a
//   stream of loads cannot starve the stores.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   st_valid_i/st_ready_o, st_addr_i[11:0], st_data_i[31:0], st_word_i
//                      store request (st_word_i: 1 = sw, 0 = sb)
//   ld_valid_i, ld_addr_i[11:0], ld_word_i, ld_stall_o
//                      load request; hold and re-present while ld_stall_o
//   dm_addr_o[9:0], dm_byte_off_o[1:0], dm_word_o, dm_d_in_o[31:0], dm_wr_en_o
//                      dm_4k port
//   empty_o, count_o[PTR_W:0]
//                      occupancy for syscall/halt logic
// ---------------------------------------------------------------------------

// Per-slot compare: slot is live if it lies within count entries of the head,
// and hits if its word address matches the load's word address.
module dm_sb_slot_cmp #(
   parameter int PTR_W = 2,
   parameter int IDX   = 0
) (
   input  logic [PTR_W-1:0] rd_ptr_i,
   input  logic [PTR_W:0]   count_i,
   input  logic [9:0]       slot_waddr_i,
   input  logic [9:0]       ld_waddr_i,
   output logic             hit_o
);
   logic [PTR_W-1:0] age;

   always_comb begin
      // distance from head, wraps modulo DEPTH
      age   = PTR_W'(IDX) - rd_ptr_i;
      hit_o = ({1'b0, age} < count_i) && (slot_waddr_i == ld_waddr_i);
   end
endmodule

module dm_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             st_valid_i,
   output logic             st_ready_o,
   input  logic [11:0]      st_addr_i,
   input  logic [31:0]      st_data_i,
   input  logic             st_word_i,
   input  logic             ld_valid_i,
   input  logic [11:0]      ld_addr_i,
   input  logic             ld_word_i,
   output logic             ld_stall_o,
   output logic [9:0]       dm_addr_o,
   output logic [1:0]       dm_byte_off_o,
   output logic             dm_word_o,
   output logic [31:0]      dm_d_in_o,
   output logic             dm_wr_en_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o
);

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
      logic        word;
   } sb_entry_t;

   sb_entry_t           slot_q [DEPTH];
   sb_entry_t           head;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]      count_q, count_d;
   logic [DEPTH-1:0]    hit;
   logic                full, conflict, grant_ld, drain, enq;

   // ---------------- per-slot conflict detection ----------------
   for (genvar g = 0; g < DEPTH; g++) begin : g_slot
      dm_sb_slot_cmp #(
         .PTR_W (PTR_W),
         .IDX   (g)
      ) u_cmp (
         .rd_ptr_i     (rd_ptr_q),
         .count_i      (count_q),
         .slot_waddr_i (slot_q[g].addr[11:2]),
         .ld_waddr_i   (ld_addr_i[11:2]),
         .hit_o        (hit[g])
      );
   end

   // ---------------- arbitration ----------------
   // Everything is judged on registered state only: a store accepted this
   // cycle is invisible to the conflict check and cannot drain until the next.
   always_comb begin
      full     = (count_q == (PTR_W+1)'(DEPTH));
      conflict = ld_valid_i && (|hit);
      grant_ld = ld_valid_i && !conflict && !full;
      drain    = !grant_ld && (count_q != '0);
      enq      = st_valid_i && !full;
      head     = slot_q[rd_ptr_q];
   end

   always_comb begin
      st_ready_o    = !full;
      ld_stall_o    = ld_valid_i && !grant_ld;
      dm_wr_en_o    = drain;
      dm_d_in_o     = head.data;
      // load path is the default mux leg, also while idle
      dm_addr_o     = ld_addr_i[11:2];
      dm_byte_off_o = ld_addr_i[1:0];
      dm_word_o     = ld_word_i;
      if (drain) begin
         dm_addr_o     = head.addr[11:2];
         dm_byte_off_o = head.addr[1:0];
         dm_word_o     = head.word;
      end
      empty_o = (count_q == '0);
      count_o = count_q;
   end

   // ---------------- pointer / count next state ----------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (drain) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({enq, drain})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage is not reset; count gates every use of it.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         slot_q[wr_ptr_q] <= '{addr: st_addr_i, data: st_data_i, word: st_word_i};
      end
   end

endmodule
